// File: rtl/ne_window_acc_pkg.sv
// Shared definitions for the NE window accumulator.
//   state_e          : FSM encoding (prime the upstream delay line, then accumulate)
//   NePrimeSamples   : valid samples discarded after reset/clear
//   ne_log2()        : ceil(log2(n)) usable in constant expressions (window shift amount)
package ne_window_acc_pkg;

  typedef enum logic [0:0] {
    StPrime = 1'b0,
    StAccum = 1'b1
  } state_e;

  localparam int unsigned NePrimeSamples = 2;

  function automatic int unsigned ne_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ne_window_acc_if.sv
// Stream bus between the NE unit / control (master) and the window accumulator (slave).
//   clr        : sync restart, active-high
//   din        : signed NE sample
//   din_valid  : din qualifier
//   threshold  : signed detect threshold
//   sum        : signed window sum (held)
//   mean       : signed window mean, floor(sum / WIN_LEN) (held)
//   sum_valid  : one-cycle pulse when sum/mean/detect update
//   detect     : mean > threshold (held)
interface ne_window_acc_if #(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned ACC_WIDTH = 72
);
  logic                 clr;
  logic [IN_WIDTH-1:0]  din;
  logic                 din_valid;
  logic [IN_WIDTH-1:0]  threshold;
  logic [ACC_WIDTH-1:0] sum;
  logic [IN_WIDTH-1:0]  mean;
  logic                 sum_valid;
  logic                 detect;

  modport master (
    output clr, din, din_valid, threshold,
    input  sum, mean, sum_valid, detect
  );

  modport slave (
    input  clr, din, din_valid, threshold,
    output sum, mean, sum_valid, detect
  );
endinterface

// File: rtl/ne_window_acc.sv
// Accumulates signed NE samples over non-overlapping windows of WIN_LEN valid samples and
// emits the window sum, mean (arithmetic shift, floor) and a threshold-detect flag.
// The first NePrimeSamples valid samples after reset/clear are discarded.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : slave side of ne_window_acc_if (clr, din, din_valid, threshold in;
//          sum, mean, sum_valid, detect out)
module ne_window_acc
  import ne_window_acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned WIN_LEN   = 256,
  parameter int unsigned ACC_WIDTH = IN_WIDTH + $clog2(WIN_LEN)
) (
  input  logic           clk,
  input  logic           rst,
  ne_window_acc_if.slave bus
);

  localparam int unsigned WinLog2 = ne_log2(WIN_LEN);
  localparam int unsigned SkipW   = (NePrimeSamples > 1) ? ne_log2(NePrimeSamples) : 1;
  localparam logic [WinLog2-1:0] CntLast  = WinLog2'(WIN_LEN - 1);
  localparam logic [SkipW-1:0]   SkipLast = SkipW'(NePrimeSamples - 1);

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [WinLog2-1:0]          cnt_q, cnt_d;
  logic [SkipW-1:0]            skip_q, skip_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic signed [IN_WIDTH-1:0]  mean_q, mean_d;
  logic                        sum_valid_q, sum_valid_d;
  logic                        detect_q, detect_d;

  logic signed [ACC_WIDTH-1:0] din_ext;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [IN_WIDTH-1:0]  mean_next;

  // Sign-extend the sample; the accumulator is wide enough that a full window cannot overflow.
  assign din_ext   = ACC_WIDTH'($signed(bus.din));
  assign acc_sum   = acc_q + din_ext;
  // Shifted sum always fits IN_WIDTH, so truncation is exact.
  assign mean_next = IN_WIDTH'(acc_sum >>> WinLog2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StPrime;
      acc_q       <= '0;
      cnt_q       <= '0;
      skip_q      <= '0;
      sum_q       <= '0;
      mean_q      <= '0;
      sum_valid_q <= 1'b0;
      detect_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
      sum_valid_q <= sum_valid_d;
      detect_q    <= detect_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    detect_d    = detect_q;
    sum_valid_d = 1'b0;

    if (bus.clr) begin
      // Restart wins over a coincident sample, even a window-completing one.
      state_d = StPrime;
      acc_d   = '0;
      cnt_d   = '0;
      skip_d  = '0;
    end else if (bus.din_valid) begin
      unique case (state_q)
        StPrime: begin
          skip_d = skip_q + 1'b1;
          if (skip_q == SkipLast) begin
            state_d = StAccum;
          end
        end
        StAccum: begin
          if (cnt_q == CntLast) begin
            sum_d       = acc_sum;
            mean_d      = mean_next;
            detect_d    = (mean_next > $signed(bus.threshold));
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StPrime;
      endcase
    end
  end

  assign bus.sum       = sum_q;
  assign bus.mean      = mean_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.detect    = detect_q;

endmodule

// File: tb/tb_ne_window_acc.sv
// Scoreboard bench for ne_window_acc (WIN_LEN=4, IN_WIDTH=16): directed scenarios followed by
// randomized traffic. A window-level reference model pushes expected results; a monitor on the
// opposite clock edge pops them on each sum_valid pulse and checks held outputs otherwise.
module tb_ne_window_acc;

  localparam int unsigned IW  = 16;
  localparam int unsigned WL  = 4;
  localparam int unsigned AW  = IW + $clog2(WL);
  localparam int          NPR = 2;

  typedef struct {
    longint sum;
    longint mean;
    bit     det;
  } res_t;

  logic clk;
  logic rst;

  ne_window_acc_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW)) bus ();

  ne_window_acc #(
    .IN_WIDTH (IW),
    .WIN_LEN  (WL),
    .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;
  int   pulses = 0;

  // Reference model state: samples of the current window, primed count, held results.
  int   primed;
  int   win[$];
  res_t exp_q[$];
  res_t held;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_step(input bit v, input logic [IW-1:0] d, input logic [IW-1:0] th,
                            input bit c, input bit r);
    longint s;
    res_t   e;
    if (!r) begin
      win.delete();
      primed = 0;
      held   = '{0, 0, 0};
      exp_q.delete();
    end else if (c) begin
      win.delete();
      primed = 0;
    end else if (v) begin
      if (primed < NPR) begin
        primed++;
      end else begin
        win.push_back(int'($signed(d)));
        if (win.size() == WL) begin
          s = 0;
          foreach (win[i]) s += win[i];
          e.sum  = s;
          e.mean = floor_div(s, WL);
          e.det  = (e.mean > longint'($signed(th)));
          held   = e;
          exp_q.push_back(e);
          win.delete();
        end
      end
    end
  endtask

  // One clock of stimulus: drive on the falling edge, update the model just after the rise.
  task automatic cyc(input bit v, input logic [IW-1:0] d, input logic [IW-1:0] th,
                     input bit c, input bit r);
    @(negedge clk);
    rst           = r;
    bus.clr       = c;
    bus.din_valid = v;
    bus.din       = v ? d : IW'($urandom);
    bus.threshold = th;
    @(posedge clk);
    #1;
    model_step(v, d, th, c, r);
  endtask

  task automatic samp(input int d, input int th);
    cyc(1'b1, IW'(d), IW'(th), 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.sum_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("pulse_sum", longint'($signed(bus.sum)), e.sum);
          chk("pulse_mean", longint'($signed(bus.mean)), e.mean);
          chk("pulse_detect", longint'(bus.detect), longint'(e.det));
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("missed_pulse", 0, 1);
          exp_q.delete();
        end
        chk("held_sum", longint'($signed(bus.sum)), held.sum);
        chk("held_mean", longint'($signed(bus.mean)), held.mean);
        chk("held_detect", longint'(bus.detect), longint'(held.det));
      end
    end
  end

  initial begin
    int p0;
    rst           = 1'b0;
    bus.clr       = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.threshold = '0;

    // 1: reset for three cycles, then idle with no pulse.
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_sum", longint'($signed(bus.sum)), 0);
    chk("rst_mean", longint'($signed(bus.mean)), 0);
    chk("rst_valid", longint'(bus.sum_valid), 0);
    chk("rst_detect", longint'(bus.detect), 0);
    mon_en = 1;
    p0 = pulses;
    idle(10);
    chk("idle_no_pulse", pulses - p0, 0);

    // 2: two priming samples discarded, then 1..4.
    samp(100, 1); samp(200, 1);
    samp(1, 1); samp(2, 1); samp(3, 1); samp(4, 1);
    idle(2);
    chk("basic_pulse_count", pulses - p0, 1);

    // 3: negative sums floor; strict compare against threshold.
    samp(-5, 0); samp(-5, 0); samp(-5, 0); samp(-6, -7);
    idle(1);
    samp(-5, 0); samp(-5, 0); samp(-5, 0); samp(-6, -6);
    idle(1);

    // 4: eight 3s with gaps inside the first window.
    p0 = pulses;
    samp(3, 0); samp(3, 0); idle(3);
    samp(3, 0); samp(3, 0); samp(3, 0); samp(3, 0); samp(3, 0); samp(3, 0);
    idle(1);
    chk("gap_pulse_count", pulses - p0, 2);

    // 5: clear with a valid sample mid-window; re-prime, then a fresh window.
    samp(50, 0); samp(60, 0);
    cyc(1'b1, IW'(70), '0, 1'b1, 1'b1);
    idle(2);
    samp(900, 0); samp(901, 0);
    samp(7, 0); samp(8, 0); samp(9, 0); samp(10, 0);
    idle(1);

    // 6: reset at cnt==3; outputs zero, re-prime required.
    samp(1, 0); samp(1, 0); samp(1, 0);
    cyc(1'b1, IW'(1), '0, 1'b0, 1'b0);
    chk("midrst_sum", longint'($signed(bus.sum)), 0);
    chk("midrst_valid", longint'(bus.sum_valid), 0);
    samp(-1, 0); samp(-1, 0);
    samp(-8, -9); samp(-8, -9); samp(-8, -9); samp(-9, -9);
    idle(1);

    // Randomized traffic: sparse valids, occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      bit v, c, r;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 199) != 0);
      cyc(v, IW'($urandom), IW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 15)),
          c, r);
    end
    idle(2);
    chk("pending_at_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
